instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 28 ++
 rtl/instr_fetch_unit_pc_reg.sv | 25 ++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor definitions: fetch FSM encoding, halt opcode and instruction field layout.
// Imported by the fetch unit and the control unit.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

   localparam logic [5:0] HALT_OP_DEFAULT = 6'h3F;

   localparam int INSTR_W  = 32;
   localparam int OP_MSB   = 31;
   localparam int OP_LSB   = 26;
   localparam int OPND_MSB = 25;
   localparam int OPND_LSB = 0;

   function automatic logic [OP_MSB-OP_LSB:0] instr_opcode(input logic [INSTR_W-1:0] w);
      return w[OP_MSB:OP_LSB];
   endfunction

   function automatic logic [OPND_MSB-OPND_LSB:0] instr_operand(input logic [INSTR_W-1:0] w);
      return w[OPND_MSB:OPND_LSB];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: parallel load (branch) or increment, wrapping naturally at 2^ADDR_W.
// Load wins over increment when both are requested.
module pc_reg #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              incr,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_VAL;
      end else if (load) begin
         pc <= load_val;
      end else if (incr) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches a word at PC, holds it for the control unit until retired,
// then advances or branches. A retired HALT_OP parks the unit until reset.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BOOT  | one cycle after reset release, nothing driven
//   ST_FETCH | mem_rd=1 at PC, waiting for mem_ready
//   ST_ISSUE | instruction held in IR, op_valid=1, waiting for instr_done
//   ST_HALT  | halt opcode retired; only reset leaves
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [5:0]        HALT_OP  = HALT_OP_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       mem_data,
   input  logic              mem_ready,
   output logic [5:0]        OPCode,
   output logic [25:0]       operand,
   output logic              op_valid,
   input  logic              instr_done,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              halted
);

   fetch_state_t        state, state_nxt;
   logic [INSTR_W-1:0]  ir;
   logic                ir_load;
   logic                pc_load;
   logic                pc_incr;
   logic [ADDR_W-1:0]   pc;

   pc_reg #(
      .ADDR_W    (ADDR_W),
      .RESET_VAL (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst_n    (reset),
      .load     (pc_load),
      .incr     (pc_incr),
      .load_val (branch_target),
      .pc       (pc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ir_load   = 1'b0;
      pc_load   = 1'b0;
      pc_incr   = 1'b0;
      mem_rd    = 1'b0;
      op_valid  = 1'b0;
      halted    = 1'b0;
      case (state)
         ST_BOOT: begin
            state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               ir_load   = 1'b1;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            op_valid = 1'b1;
            if (instr_done) begin
               // halt retirement freezes PC and disregards any branch request
               if (instr_opcode(ir) == HALT_OP) begin
                  state_nxt = ST_HALT;
               end else begin
                  state_nxt = ST_FETCH;
                  pc_load   = branch_taken;
                  pc_incr   = ~branch_taken;
               end
            end
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_nxt = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir <= '0;
      end else if (ir_load) begin
         ir <= mem_data;
      end
   end

   assign mem_addr = pc;
   assign OPCode   = instr_opcode(ir);
   assign operand  = instr_operand(ir);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios followed by random episodes,
// all checked against a transaction-level model of fetch/issue/retire.
module tb_instr_fetch_unit;

   localparam int M_BOOT  = 0;
   localparam int M_FETCH = 1;
   localparam int M_ISSUE = 2;
   localparam int M_HALT  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [31:0] mem_data = '0;
   logic        mem_ready = 1'b0;
   logic [5:0]  OPCode;
   logic [25:0] operand;
   logic        op_valid;
   logic        instr_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = '0;
   logic        halted;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [256];

   typedef struct packed {
      logic [5:0]  op;
      logic [25:0] opnd;
   } exp_t;
   exp_t exp_q[$];

   int          m_state = M_BOOT;
   int          ref_pc  = 0;
   logic [31:0] m_ir    = '0;

   instr_fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .mem_addr      (mem_addr),
      .mem_rd        (mem_rd),
      .mem_data      (mem_data),
      .mem_ready     (mem_ready),
      .OPCode        (OPCode),
      .operand       (operand),
      .op_valid      (op_valid),
      .instr_done    (instr_done),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      check("mem_rd", 32'(mem_rd), 32'(m_state == M_FETCH));
      check("mem_addr", 32'(mem_addr), 32'(ref_pc));
      check("op_valid", 32'(op_valid), 32'(m_state == M_ISSUE));
      check("halted", 32'(halted), 32'(m_state == M_HALT));
      if (m_state == M_ISSUE) begin
         check("hold_opcode", 32'(OPCode), 32'(m_ir[31:26]));
         check("hold_operand", 32'(operand), 32'(m_ir[25:0]));
      end
   endtask

   // Applies one cycle of stimulus at a negedge, advances the model across the coming
   // posedge, and checks the DUT at the following negedge.
   task automatic drive(input bit rdy, input bit done, input bit br, input logic [7:0] tgt);
      mem_ready     = rdy;
      instr_done    = done;
      branch_taken  = br;
      branch_target = tgt;
      mem_data      = (m_state == M_FETCH) ? mem[ref_pc] : $urandom;
      case (m_state)
         M_BOOT: m_state = M_FETCH;
         M_FETCH: begin
            if (rdy) begin
               m_ir = mem[ref_pc];
               exp_q.push_back(exp_t'(m_ir));
               m_state = M_ISSUE;
            end
         end
         M_ISSUE: begin
            if (done) begin
               if (m_ir[31:26] == 6'h3F) begin
                  m_state = M_HALT;
               end else begin
                  ref_pc  = br ? int'(tgt) : (ref_pc + 1) % 256;
                  m_state = M_FETCH;
               end
            end
         end
         default: ;
      endcase
      @(negedge clk);
      check_state();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_op_valid", 32'(op_valid), 32'd0);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'h00);
      check("rst_opcode", 32'(OPCode), 32'd0);
      m_state = M_BOOT;
      ref_pc  = 0;
      m_ir    = '0;
      exp_q.delete();
      mem_ready  = 1'b0;
      instr_done = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("boot_mem_rd", 32'(mem_rd), 32'd0);
   endtask

   // Monitor: each new instruction presented must match the next scoreboard entry.
   initial begin
      logic prev_valid;
      exp_t e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (op_valid === 1'b1 && !prev_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL issue_unexpected: got op %h operand %h expected no instruction", OPCode, operand);
            end else begin
               e = exp_q.pop_front();
               check("issue_opcode", 32'(OPCode), 32'(e.op));
               check("issue_operand", 32'(operand), 32'(e.opnd));
            end
         end
         prev_valid = (op_valid === 1'b1);
      end
   end

   initial begin
      int after_halt;
      reset = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = {6'h05, 26'($urandom)};
      mem[0]     = 32'h0400_0005;
      mem[1]     = 32'h0800_0001;
      mem[8'h40] = 32'h0C00_0002;
      mem[8'hFF] = 32'h1000_0003;
      mem[8'h80] = 32'hFC00_0000;
      @(negedge clk);
      do_reset();

      // sequential fetch with two wait cycles
      drive(0, 0, 0, 8'h00);
      check("seq_first_addr", 32'(mem_addr), 32'h00);
      check("seq_first_rd", 32'(mem_rd), 32'd1);
      drive(0, 0, 0, 8'h00);
      drive(0, 0, 0, 8'h00);
      drive(1, 0, 0, 8'h00);
      check("seq_opcode", 32'(OPCode), 32'h01);
      check("seq_operand", 32'(operand), 32'h5);
      check("seq_valid", 32'(op_valid), 32'd1);
      drive(0, 1, 0, 8'h00);
      check("seq_next_addr", 32'(mem_addr), 32'h01);

      // branch to 0x40, then to 0xFF, then wrap to 0x00
      drive(1, 0, 0, 8'h00);
      drive(0, 1, 1, 8'h40);
      check("branch_addr", 32'(mem_addr), 32'h40);
      drive(1, 0, 0, 8'h00);
      drive(0, 1, 1, 8'hFF);
      check("branch_ff_addr", 32'(mem_addr), 32'hFF);
      drive(1, 0, 0, 8'h00);
      drive(0, 1, 0, 8'h00);
      check("wrap_addr", 32'(mem_addr), 32'h00);

      // spurious instr_done in FETCH, spurious mem_ready in ISSUE
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 8'h33);
      check("spur_fetch_addr", 32'(mem_addr), 32'h00);
      drive(1, 0, 0, 8'h00);
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 8'h00);
      check("spur_issue_opcode", 32'(OPCode), 32'h01);
      check("spur_issue_operand", 32'(operand), 32'h5);

      // halt retirement with a branch request that must be ignored
      drive(0, 1, 1, 8'h80);
      drive(1, 0, 0, 8'h00);
      drive(0, 1, 1, 8'h11);
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_addr", 32'(mem_addr), 32'h80);
      for (int i = 0; i < 20; i++) drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      check("halt_rd_after", 32'(mem_rd), 32'd0);

      // reset while an instruction is being issued
      do_reset();
      drive(0, 0, 0, 8'h00);
      drive(1, 0, 0, 8'h00);
      check("pre_rst_valid", 32'(op_valid), 32'd1);
      do_reset();
      drive(0, 0, 0, 8'h00);
      check("refetch_rd", 32'(mem_rd), 32'd1);
      check("refetch_addr", 32'(mem_addr), 32'h00);

      // random episodes
      for (int ep = 0; ep < 6; ep++) begin
         for (int i = 0; i < 256; i++) mem[i] = $urandom;
         do_reset();
         after_halt = 0;
         for (int cyc = 0; cyc < 400 && after_halt < 10; cyc++) begin
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, 8'($urandom));
            if (m_state == M_HALT) after_halt++;
         end
      end

      drive(0, 0, 0, 8'h00);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
